unpool_stream: RTL and testbench

- Streaming binary un-pooling (nearest-neighbour upsample). It is the inverse-direction counterpart of the OR-based binary max-pool stage.
- Accepts one pooled feature-map row per valid/ready handshake.
- Replicates each bit POOL_SIZE times horizontally and emits each expanded row POOL_SIZE times vertically, on a valid/ready output stream.
- Sits between a pooled-layer producer and a full-resolution consumer. Marks the last output row of each frame.

---
 rtl/unpool_pkg.sv | 16 +
 rtl/unpool_row_expand.sv | 14 +
 rtl/unpool_stream.sv | 97 +++++++++
 tb/tb_unpool_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpool_pkg.sv
// Shared types and helpers for the binary un-pooling stream.
package unpool_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/unpool_row_expand.sv
// Nearest-neighbour horizontal expansion: each pooled bit drives POOL_SIZE columns.
module unpool_row_expand #(
    parameter int unsigned IN_L      = 13,
    parameter int unsigned POOL_SIZE = 2
) (
    input  logic [IN_L-1:0]           in_row,
    output logic [IN_L*POOL_SIZE-1:0] out_row_c
);

    for (genvar c = 0; c < IN_L * POOL_SIZE; c++) begin : g_col
        assign out_row_c[c] = in_row[c / POOL_SIZE];
    end

endmodule

// File: rtl/unpool_stream.sv
// Streaming binary un-pooling: widens each pooled row and repeats it POOL_SIZE times,
// flagging the final output row of every frame.
module unpool_stream
    import unpool_pkg::*;
#(
    parameter int unsigned ISIZE_L   = 26,
    parameter int unsigned ISIZE_H   = 26,
    parameter int unsigned POOL_SIZE = 2,
    localparam int unsigned IN_L     = ISIZE_L / POOL_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_L-1:0]    in_row,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ISIZE_L-1:0] out_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);

    localparam int unsigned IN_H  = ISIZE_H / POOL_SIZE;
    localparam int unsigned REP_W = clog2_min1(POOL_SIZE);
    localparam int unsigned ROW_W = clog2_min1(IN_H);

    localparam logic [REP_W-1:0] REP_MAX = REP_W'(POOL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IN_H - 1);

    if ((POOL_SIZE < 2) || ((ISIZE_L % POOL_SIZE) != 0) || ((ISIZE_H % POOL_SIZE) != 0)) begin : g_bad_params
        $fatal(1, "unpool_stream: ISIZE_L/ISIZE_H must be multiples of POOL_SIZE and POOL_SIZE >= 2");
    end

    state_t               state;
    logic [REP_W-1:0]     rep_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic [ISIZE_L-1:0]   expanded;
    logic                 rep_last;

    unpool_row_expand #(
        .IN_L      (IN_L),
        .POOL_SIZE (POOL_SIZE)
    ) u_expand (
        .in_row    (in_row),
        .out_row_c (expanded)
    );

    assign rep_last = (rep_cnt == REP_MAX);

    // A new row is taken when idle, or as the final repetition of the current row leaves.
    assign in_ready = (state == IDLE) || (out_ready && rep_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            rep_cnt   <= '0;
            row_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_row   <= expanded;
                        rep_cnt   <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (!rep_last) begin
                            rep_cnt  <= rep_cnt + REP_W'(1);
                            out_last <= (row_cnt == ROW_MAX) && ((rep_cnt + REP_W'(1)) == REP_MAX);
                        end else begin
                            row_cnt  <= (row_cnt == ROW_MAX) ? '0 : row_cnt + ROW_W'(1);
                            out_last <= 1'b0;
                            if (in_valid) begin
                                out_row <= expanded;
                                rep_cnt <= '0;
                            end else begin
                                out_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unpool_stream.sv
// Self-checking bench for unpool_stream: queue-based beat model plus directed literal pins.
module tb_unpool_stream;

    localparam int unsigned ISIZE_L   = 26;
    localparam int unsigned ISIZE_H   = 26;
    localparam int unsigned POOL_SIZE = 2;
    localparam int unsigned IN_L      = ISIZE_L / POOL_SIZE;
    localparam int unsigned IN_H      = ISIZE_H / POOL_SIZE;
    localparam int unsigned FRAME_BEATS = ISIZE_H;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [IN_L-1:0]    in_row = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ISIZE_L-1:0] out_row;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_last;

    unpool_stream #(
        .ISIZE_L   (ISIZE_L),
        .ISIZE_H   (ISIZE_H),
        .POOL_SIZE (POOL_SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_row    (in_row),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [ISIZE_L-1:0] expand(input logic [IN_L-1:0] r);
        logic [ISIZE_L-1:0] e;
        for (int c = 0; c < ISIZE_L; c++) e[c] = r[c / POOL_SIZE];
        return e;
    endfunction

    typedef struct {
        logic [ISIZE_L-1:0] row;
        logic               last;
    } beat_t;

    // Model state: beats still owed downstream and position within the frame.
    beat_t q[$];
    int    model_row = 0;
    int    cyc = 0;
    int    fire_cyc[$];
    bit    fire_last[$];
    logic [ISIZE_L-1:0] fire_row[$];

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            model_row = 0;
            cyc = 0;
            fire_cyc.delete();
            fire_last.delete();
            fire_row.delete();
        end else begin
            bit exp_ready;
            bit fire;
            cyc++;
            exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
            fire = (q.size() != 0) && out_ready;
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (q.size() != 0) begin
                chk("out_row", 32'(out_row), 32'(q[0].row));
                chk("out_last", 32'(out_last), 32'(q[0].last));
            end
            if (fire) begin
                fire_cyc.push_back(cyc);
                fire_last.push_back(q[0].last);
                fire_row.push_back(out_row);
                void'(q.pop_front());
            end
            if (in_valid && exp_ready) begin
                for (int r = 0; r < POOL_SIZE; r++) begin
                    beat_t b;
                    b.row  = expand(in_row);
                    b.last = (model_row == IN_H - 1) && (r == POOL_SIZE - 1);
                    q.push_back(b);
                end
                model_row = (model_row + 1) % IN_H;
            end
        end
    end

    // out_ready pattern: 0 = always, 1 = random, 2 = repeating 1,0,0,1.
    int or_mode = 0;
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = pat[ph];
                    ph = (ph + 1) % 4;
                end
            endcase
        end
    end

    task automatic send_row(input logic [IN_L-1:0] r);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_row = r;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 500) begin
                chk("send_timeout", 32'd0, 32'd1);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_row = IN_L'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_row", 32'(out_row), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic check_lasts(input int n, input int a, input int b);
        chk("fire_count", 32'(fire_last.size()), 32'(n));
        for (int i = 0; i < n && i < fire_last.size(); i++)
            chk("last_pos", 32'(fire_last[i]), 32'((i == a) || (i == b)));
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_out_valid0", 32'(out_valid), 32'd0);
        chk("rst_out_row0", 32'(out_row), 32'd0);
        chk("rst_out_last0", 32'(out_last), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed: two rows at full speed, literal outputs
        or_mode = 0;
        send_row(13'h0001);
        send_row(13'h1000);
        wait_drain();
        chk("dir_beats", 32'(fire_row.size()), 32'd4);
        if (fire_row.size() == 4) begin
            chk("dir_row0", 32'(fire_row[0]), 32'h0000003);
            chk("dir_row1", 32'(fire_row[1]), 32'h0000003);
            chk("dir_row2", 32'(fire_row[2]), 32'h3000000);
            chk("dir_row3", 32'(fire_row[3]), 32'h3000000);
            chk("dir_nolast", 32'(fire_last[0] | fire_last[1] | fire_last[2] | fire_last[3]), 32'd0);
        end

        // Back-to-back over two full frames
        do_reset();
        or_mode = 0;
        for (int i = 0; i < 2 * IN_H; i++) send_row(IN_L'($urandom));
        wait_drain();
        check_lasts(2 * FRAME_BEATS, FRAME_BEATS - 1, 2 * FRAME_BEATS - 1);
        if (fire_cyc.size() == 2 * FRAME_BEATS)
            chk("no_bubble", 32'(fire_cyc[2 * FRAME_BEATS - 1] - fire_cyc[0]), 32'(2 * FRAME_BEATS - 1));

        // Backpressure 1,0,0,1
        do_reset();
        or_mode = 2;
        for (int i = 0; i < 6; i++) send_row(IN_L'($urandom));
        wait_drain();
        chk("bp_beats", 32'(fire_row.size()), 32'd12);

        // Reset mid-frame, then a full fresh frame
        do_reset();
        or_mode = 0;
        for (int i = 0; i < 5; i++) send_row(IN_L'($urandom));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < IN_H; i++) send_row(IN_L'($urandom));
        wait_drain();
        check_lasts(FRAME_BEATS, FRAME_BEATS - 1, FRAME_BEATS - 1);

        // Idle gap between rows
        do_reset();
        or_mode = 0;
        send_row(IN_L'($urandom));
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("gap_out_valid", 32'(out_valid), 32'd0);
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i < IN_H; i++) send_row(IN_L'($urandom));
        wait_drain();
        check_lasts(FRAME_BEATS, FRAME_BEATS - 1, FRAME_BEATS - 1);

        // Random traffic with random gaps and random backpressure
        do_reset();
        or_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_row(IN_L'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();
        chk("rand_beats", 32'(fire_row.size()), 32'd80);
        chk("rand_last_at_26", 32'(fire_last[FRAME_BEATS - 1]), 32'd1);
        chk("rand_last_at_52", 32'(fire_last[2 * FRAME_BEATS - 1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
